out_port_allocator: RTL

- Per-output-port allocator for the credit-based router: arbitrates among the five input ports and holds one winner for a whole packet (header to tail).
- Produces the one-hot select that drives the crossbar for this output, plus the input-FIFO read strobes.
- Tracks downstream buffer credits so that flits leave only when the neighbour can accept them.
- Instantiated once per output direction: N, E, W, S, L.

---
 rtl/out_port_allocator_pkg.sv | 24 ++
 rtl/out_port_allocator_rr_arbiter_5.sv | 23 ++
 rtl/out_port_allocator.sv | 111 +++++++++++
 3 files changed

// File: rtl/out_port_allocator_pkg.sv
// Shared router types: port indices, one-hot port vector and allocator state.
package out_port_allocator_pkg;

    localparam int unsigned NUM_PORTS = 5;

    localparam int unsigned LOCAL = 0;
    localparam int unsigned SOUTH = 1;
    localparam int unsigned WEST  = 2;
    localparam int unsigned EAST  = 3;
    localparam int unsigned NORTH = 4;

    typedef logic [NUM_PORTS-1:0] port_onehot_t;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } alloc_state_t;

    // Next round-robin start: one position above the winner, N wraps to L.
    function automatic port_onehot_t rotl1(input port_onehot_t p);
        return {p[NORTH-1:LOCAL], p[NORTH]};
    endfunction

endpackage

// File: rtl/out_port_allocator_rr_arbiter_5.sv
// Combinational 5-way round-robin pick: first set req bit at or above rr_ptr, wrapping N -> L.
module rr_arbiter_5
    import out_port_allocator_pkg::*;
(
    input  port_onehot_t req,
    input  port_onehot_t rr_ptr,
    output port_onehot_t winner
);

    logic armed;

    // Walk the ports twice so the search can wrap past N back to the pointer.
    always_comb begin
        winner = '0;
        armed  = 1'b0;
        for (int k = 0; k < int'(2 * NUM_PORTS); k++) begin
            if (rr_ptr[k % int'(NUM_PORTS)]) armed = 1'b1;
            if (armed && req[k % int'(NUM_PORTS)] && (winner == '0))
                winner[k % int'(NUM_PORTS)] = 1'b1;
        end
    end

endmodule

// File: rtl/out_port_allocator.sv
// Per-output-port packet allocator with downstream credit tracking.
// OUT_ALLOC_BACK2BACK_EN: re-arbitrate in the tail cycle so a new packet starts without a bubble.
module out_port_allocator
    import out_port_allocator_pkg::*;
#(
    parameter int unsigned CREDIT_MAX = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] req,
    input  logic [4:0] flit_valid,
    input  logic [4:0] tail,
    input  logic       credit_in,
    output logic [4:0] grant,
    output logic [4:0] read_en,
    output logic       valid_out
);

    localparam int unsigned CNT_W = $clog2(CREDIT_MAX + 1);

    alloc_state_t     state_q, state_d;
    port_onehot_t     grant_d;
    port_onehot_t     rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] credit_q, credit_d;
    port_onehot_t     win;
    logic             xfer;
    logic             tail_xfer;

    rr_arbiter_5 u_arb (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .winner (win)
    );

`ifdef OUT_ALLOC_BACK2BACK_EN
    port_onehot_t win_b2b;

    // Same pointer, but the departing packet's own request is masked off.
    rr_arbiter_5 u_arb_b2b (
        .req    (req & ~grant),
        .rr_ptr (rr_ptr_q),
        .winner (win_b2b)
    );
`endif

    assign xfer      = (state_q == LOCKED) && (|(flit_valid & grant)) && (credit_q != '0);
    assign tail_xfer = xfer && (|(tail & grant));

    // Next-state and flit-movement strobes.
    always_comb begin
        state_d   = state_q;
        grant_d   = grant;
        rr_ptr_d  = rr_ptr_q;
        read_en   = grant & {NUM_PORTS{xfer}};
        valid_out = xfer;
        case (state_q)
            IDLE: begin
                if (req != '0) begin
                    state_d  = LOCKED;
                    grant_d  = win;
                    rr_ptr_d = rotl1(win);
                end
            end
            LOCKED: begin
                if (tail_xfer) begin
`ifdef OUT_ALLOC_BACK2BACK_EN
                    if (win_b2b != '0) begin
                        grant_d  = win_b2b;
                        rr_ptr_d = rotl1(win_b2b);
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
`else
                    state_d = IDLE;
                    grant_d = '0;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Credits: a returned credit and a departing flit cancel; saturate at CREDIT_MAX.
    always_comb begin
        credit_d = credit_q;
        case ({xfer, credit_in})
            2'b10:   credit_d = credit_q - CNT_W'(1);
            2'b01:   if (credit_q != CNT_W'(CREDIT_MAX)) credit_d = credit_q + CNT_W'(1);
            default: credit_d = credit_q;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            grant    <= '0;
            rr_ptr_q <= port_onehot_t'(1);
            credit_q <= CNT_W'(CREDIT_MAX);
        end else begin
            state_q  <= state_d;
            grant    <= grant_d;
            rr_ptr_q <= rr_ptr_d;
            credit_q <= credit_d;
        end
    end

endmodule
